fmc_bram_axil_bridge: RTL and testbench

- Downstream stage of the FMC slave interface; sits on its BRAM-style port.
- Accepts single 16-bit BRAM-port accesses and turns each into one AXI4-Lite master transaction (32-bit data bus) toward the system interconnect.
- Returns read data on bram_dout and drives busy, which feeds the FMC NWAIT path so the external host stalls until the AXI transaction completes.

---
 rtl/fmc_bram_axil_bridge.sv | 173 +++++++++++++++++
 tb/tb_fmc_bram_axil_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc_bram_axil_bridge.sv
// fmc_bram_axil_bridge
//   Converts single 16-bit BRAM-port accesses coming from the FMC slave
//   interface into one AXI4-Lite master transaction each (32-bit data bus).
//   busy is high while an AXI transaction is in flight and feeds the FMC
//   NWAIT path, so the external host stalls until the transaction completes.
//
// Optional feature macro: FMC_BRAM_AXIL_TIMEOUT_EN
//   Defined     : watchdog aborts a transaction after C_TIMEOUT_CYCLES non-idle
//                 cycles, sets err_timeout and returns 16'hDEAD for reads.
//   Not defined : no watchdog, the bridge waits indefinitely, err_timeout = 0.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   bram_en/we/addr/din      BRAM-style access port (we != 0 means write)
//   bram_dout                registered read data of the last completed read
//   busy                     transaction in progress
//   err_resp/overrun/timeout sticky error flags, cleared only by reset
//   m_axi_*                  AXI4-Lite master (AW, W, B, AR, R channels)
module fmc_bram_axil_bridge #(
  parameter int                          C_ADDR_WIDTH     = 12,
  parameter int                          C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = '0,
  parameter int                          C_TIMEOUT_CYCLES = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        bram_en,
  input  logic [1:0]                  bram_we,
  input  logic [C_ADDR_WIDTH-1:0]     bram_addr,
  input  logic [15:0]                 bram_din,
  output logic [15:0]                 bram_dout,
  output logic                        busy,
  output logic                        err_resp,
  output logic                        err_overrun,
  output logic                        err_timeout,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [31:0]                 m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [31:0]                 m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_t;

  state_t                        state, state_next;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_in, addr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          lane_q, aw_done, w_done;
  logic                          accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, abort;

  // Byte address of the halfword; bit 1 picks the upper/lower 16-bit lane.
  assign addr_in = C_BASE_ADDR +
                   {{(C_AXI_ADDR_WIDTH-C_ADDR_WIDTH-1){1'b0}}, bram_addr, 1'b0};

  assign accept = bram_en && (state == IDLE);

  // Valid/ready outputs decode directly from registered state, so an abort
  // or reset drops them all at once.
  assign m_axi_awvalid = (state == WR) && !aw_done;
  assign m_axi_wvalid  = (state == WR) && !w_done;
  assign m_axi_bready  = (state == WRESP);
  assign m_axi_arvalid = (state == RADDR);
  assign m_axi_rready  = (state == RDATA);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign busy          = (state != IDLE);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bready  && m_axi_bvalid;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rready  && m_axi_rvalid;

`ifdef FMC_BRAM_AXIL_TIMEOUT_EN
  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Counts non-idle cycles; held at zero while idle so it starts fresh on
  // every accepted access.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)            to_cnt <= '0;
    else if (state == IDLE)  to_cnt <= '0;
    else                     to_cnt <= to_cnt + 1'b1;
  end

  // A response that completes in the final allowed cycle still wins.
  assign abort = (state != IDLE) && (to_cnt == TW'(C_TIMEOUT_CYCLES - 1)) &&
                 !b_hs && !r_hs;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   err_timeout <= 1'b0;
    else if (abort) err_timeout <= 1'b1;
  end
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // Write leaves WR only once both AW and W have handshaked, in either order.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bram_en) state_next = (bram_we != 2'b00) ? WR : RADDR;
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WRESP;
      WRESP:   if (b_hs) state_next = IDLE;
      RADDR:   if (ar_hs) state_next = RDATA;
      RDATA:   if (r_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Request capture, per-channel handshake tracking, read data and errors.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lane_q      <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      bram_dout   <= 16'h0000;
      err_resp    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= addr_in;
        lane_q  <= addr_in[1];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (bram_we != 2'b00) begin
          wdata_q <= {bram_din, bram_din};
          wstrb_q <= addr_in[1] ? {bram_we, 2'b00} : {2'b00, bram_we};
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (r_hs)
        bram_dout <= lane_q ? m_axi_rdata[31:16] : m_axi_rdata[15:0];
      else if (abort && ((state == RADDR) || (state == RDATA)))
        bram_dout <= 16'hDEAD;
      if (bram_en && (state != IDLE)) err_overrun <= 1'b1;
      if ((b_hs && ((m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11))) ||
          (r_hs && ((m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11))))
        err_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmc_bram_axil_bridge.sv
// tb_fmc_bram_axil_bridge
//   Self-checking bench for fmc_bram_axil_bridge. A small AXI4-Lite slave with
//   programmable per-channel latencies and responses answers the bridge; a
//   reference model derived from the address/lane rules predicts the AXI
//   request fields, bram_dout and the sticky error flags.
module tb_fmc_bram_axil_bridge;

  localparam logic [31:0] BASE       = 32'h0000_0000;
  localparam int          TO_CYCLES  = 16;
  localparam int          BUSY_LIMIT = 300;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        bram_en, busy, err_resp, err_overrun, err_timeout;
  logic [1:0]  bram_we;
  logic [11:0] bram_addr;
  logic [15:0] bram_din, bram_dout;
  logic [31:0] awaddr, araddr, wdata, rdata = 32'h0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, arready;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;

  // Slave configuration for the next access
  int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0;
  int          cfg_b_delay = 0, cfg_r_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // Slave observation state
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_timer = -1, r_timer = -1;
  bit          aw_got = 0, w_got = 0;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  int          cyc = 0, done_edge = 0, viol = 0;
  bit          aw_pend = 0, w_pend = 0, ar_pend = 0;

  // Reference model state
  logic [15:0] m_dout = 16'h0;
  bit          m_err = 0, m_ovr = 0, m_to = 0;
  int          n_checks = 0, n_fail = 0;

  fmc_bram_axil_bridge #(
    .C_ADDR_WIDTH(12), .C_AXI_ADDR_WIDTH(32), .C_BASE_ADDR(BASE),
    .C_TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .busy(busy), .err_resp(err_resp), .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  always #5 aclk = ~aclk;

  // Ready is granted once the valid has been waiting for the configured delay.
  assign awready = awvalid && (aw_wait >= cfg_aw_delay);
  assign wready  = wvalid  && (w_wait  >= cfg_w_delay);
  assign arready = arvalid && (ar_wait >= cfg_ar_delay);

  // AXI4-Lite slave: latches requests, schedules B/R responses, counts
  // handshakes and flags any valid that is withdrawn before its handshake.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_timer <= -1; r_timer <= -1;
      aw_got <= 0; w_got <= 0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_pend <= 0; w_pend <= 0; ar_pend <= 0;
    end else begin
      cyc     <= cyc + 1;
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid  && !wready)  ? w_wait  + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin
        aw_got <= 1; cap_awaddr <= awaddr; aw_hs_n <= aw_hs_n + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1; cap_wdata <= wdata; cap_wstrb <= wstrb; w_hs_n <= w_hs_n + 1;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        aw_got <= 0; w_got <= 0;
        if (cfg_b_delay == 0) begin bvalid <= 1'b1; bresp <= cfg_bresp; end
        else b_timer <= cfg_b_delay - 1;
      end else if (b_timer == 0) begin
        bvalid <= 1'b1; bresp <= cfg_bresp; b_timer <= -1;
      end else if (b_timer > 0) b_timer <= b_timer - 1;
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_hs_n <= b_hs_n + 1; done_edge <= cyc + 1;
      end
      if (arvalid && arready) begin
        cap_araddr <= araddr; ar_hs_n <= ar_hs_n + 1;
        if (cfg_r_delay == 0) begin
          rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp;
        end else r_timer <= cfg_r_delay - 1;
      end else if (r_timer == 0) begin
        rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp; r_timer <= -1;
      end else if (r_timer > 0) r_timer <= r_timer - 1;
      if (rvalid && rready) begin
        rvalid <= 1'b0; r_hs_n <= r_hs_n + 1; done_edge <= cyc + 1;
      end
      aw_pend <= awvalid && !awready;
      w_pend  <= wvalid  && !wready;
      ar_pend <= arvalid && !arready;
      if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid))
        viol <= viol + 1;
    end
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one BRAM access, optionally pokes bram_en while busy, waits for
  // completion and compares everything against the reference model.
  task automatic applyStimulus(input logic [1:0] we, input logic [11:0] addr,
                               input logic [15:0] din, input int overrun_at,
                               input bit expect_timeout, output int busy_n);
    int          aw0, w0, b0, ar0, r0;
    logic [31:0] exp_addr, shifted;
    logic        lane;
    logic [3:0]  exp_strb;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
    exp_addr = BASE + 32'(addr) * 32'd2;
    lane     = exp_addr[1];
    @(negedge aclk);
    bram_en = 1'b1; bram_we = we; bram_addr = addr; bram_din = din;
    @(negedge aclk);
    bram_en = 1'b0; bram_we = 2'b00;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    busy_n = 0;
    while (busy === 1'b1 && busy_n < BUSY_LIMIT) begin
      if (busy_n == overrun_at) begin
        bram_en = 1'b1; bram_we = 2'b11; m_ovr = 1;
      end
      @(negedge aclk);
      bram_en = 1'b0; bram_we = 2'b00;
      busy_n++;
    end
    checkOutput("busy_fall", 32'(busy), 32'd0);
    if (!expect_timeout) checkOutput("busy_fall_edge", 32'(cyc), 32'(done_edge));
    if (we != 2'b00) begin
      exp_strb = 4'(we) << (lane ? 2 : 0);
      if (cfg_bresp >= 2'd2) m_err = 1;
      checkOutput("aw_count", 32'(aw_hs_n - aw0), 32'd1);
      checkOutput("w_count", 32'(w_hs_n - w0), 32'd1);
      checkOutput("b_count", 32'(b_hs_n - b0), 32'd1);
      checkOutput("ar_count_wr", 32'(ar_hs_n - ar0), 32'd0);
      checkOutput("awaddr", cap_awaddr, exp_addr);
      checkOutput("wdata", cap_wdata, {16'(din), 16'(din)});
      checkOutput("wstrb", 32'(cap_wstrb), 32'(exp_strb));
    end else if (expect_timeout) begin
      m_dout = 16'hDEAD; m_to = 1;
      checkOutput("timeout_cycles", 32'(busy_n), 32'(TO_CYCLES));
      checkOutput("ar_count_to", 32'(ar_hs_n - ar0), 32'd0);
      checkOutput("arvalid_to", 32'(arvalid), 32'd0);
    end else begin
      shifted = cfg_rdata >> (lane ? 16 : 0);
      m_dout  = shifted[15:0];
      if (cfg_rresp >= 2'd2) m_err = 1;
      checkOutput("ar_count", 32'(ar_hs_n - ar0), 32'd1);
      checkOutput("r_count", 32'(r_hs_n - r0), 32'd1);
      checkOutput("aw_count_rd", 32'(aw_hs_n - aw0), 32'd0);
      checkOutput("araddr", cap_araddr, exp_addr);
    end
    checkOutput("bram_dout", 32'(bram_dout), 32'(m_dout));
    checkOutput("err_resp", 32'(err_resp), 32'(m_err));
    checkOutput("err_overrun", 32'(err_overrun), 32'(m_ovr));
    checkOutput("err_timeout", 32'(err_timeout), 32'(m_to));
  endtask

  task automatic setSlave(input int awd, input int wd, input int bd, input int ard,
                          input int rd, input logic [1:0] br, input logic [1:0] rr,
                          input logic [31:0] rdat);
    cfg_aw_delay = awd; cfg_w_delay = wd; cfg_b_delay = bd; cfg_ar_delay = ard;
    cfg_r_delay = rd; cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rdat;
  endtask

  initial begin
    int n;
    aresetn = 1'b0; bram_en = 1'b0; bram_we = 2'b00; bram_addr = '0; bram_din = '0;
    repeat (3) @(negedge aclk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dout", 32'(bram_dout), 32'd0);
    checkOutput("rst_errs", {29'd0, err_resp, err_overrun, err_timeout}, 32'd0);
    checkOutput("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Directed write, all ready immediately, B one cycle after AW/W
    setSlave(0, 0, 1, 0, 0, 2'b00, 2'b00, 32'h0);
    applyStimulus(2'b11, 12'h003, 16'hA55A, -1, 0, n);
    checkOutput("wr_busy_cycles", 32'(n), 32'd3);

    // Directed read with slow arready
    setSlave(0, 0, 0, 5, 1, 2'b00, 2'b00, 32'h1234_5678);
    applyStimulus(2'b00, 12'h002, 16'h0, -1, 0, n);

    // W accepted four cycles before AW
    setSlave(4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    applyStimulus(2'b01, 12'h005, 16'h1357, -1, 0, n);

    // Error responses are sticky and read data is still captured
    setSlave(0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0);
    applyStimulus(2'b10, 12'h010, 16'hBEEF, -1, 0, n);
    setSlave(0, 0, 0, 0, 2, 2'b00, 2'b11, 32'hCAFE_F00D);
    applyStimulus(2'b00, 12'h007, 16'h0, -1, 0, n);

    // Overrun: second strobe while busy is ignored
    setSlave(0, 0, 0, 3, 1, 2'b00, 2'b00, 32'h0BAD_1DEA);
    applyStimulus(2'b00, 12'h100, 16'h0, 1, 0, n);

    for (int i = 0; i < 24; i++) begin
      setSlave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom_range(2, 3)),
               ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom_range(2, 3)),
               $urandom);
      applyStimulus(2'($urandom_range(0, 3)), 12'($urandom), 16'($urandom), -1, 0, n);
    end
    checkOutput("valid_held", 32'(viol), 32'd0);

`ifdef FMC_BRAM_AXIL_TIMEOUT_EN
    setSlave(0, 0, 0, 1000000, 0, 2'b00, 2'b00, 32'h0);
    applyStimulus(2'b00, 12'h020, 16'h0, -1, 1, n);
    setSlave(0, 0, 0, 1, 1, 2'b00, 2'b00, 32'h8765_4321);
    applyStimulus(2'b00, 12'h021, 16'h0, -1, 0, n);
`endif

    // Reset in the middle of a read: no completion, everything back to reset
    setSlave(0, 0, 0, 50, 0, 2'b00, 2'b00, 32'h0);
    n = ar_hs_n;
    @(negedge aclk);
    bram_en = 1'b1; bram_we = 2'b00; bram_addr = 12'h030;
    @(negedge aclk);
    bram_en = 1'b0;
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("midrst_errs", {29'd0, err_resp, err_overrun, err_timeout}, 32'd0);
    checkOutput("midrst_dout", 32'(bram_dout), 32'd0);
    checkOutput("midrst_no_ar", 32'(ar_hs_n - n), 32'd0);
    m_dout = 16'h0; m_err = 0; m_ovr = 0; m_to = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    setSlave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hFACE_B00C);
    applyStimulus(2'b00, 12'h031, 16'h0, -1, 0, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
